// File: rtl/mlp_sample_streamer.sv
// Sequential wrapper around a combinational two-input MLP classifier: buffers labelled
// samples, presents them to the MLP, captures the class after a settle time, and scores it.
module mlp_sample_streamer #(
  parameter int DATA_W        = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x1,
  input  logic signed [DATA_W-1:0] in_x2,
  input  logic                     in_label,
  output logic signed [DATA_W-1:0] mlp_x1,
  output logic signed [DATA_W-1:0] mlp_x2,
  input  logic                     mlp_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_y,
  output logic                     out_label,
  output logic                     out_match,
  input  logic                     clear_counts,
  output logic [CNT_W-1:0]         sample_count,
  output logic [CNT_W-1:0]         correct_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic signed [DATA_W-1:0] fifo_x1 [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_x2 [FIFO_DEPTH];
  logic                     fifo_lbl [FIFO_DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr;
  logic                     full, empty, push, pop, capture, hs;
  state_t                   state_q, state_d;
  logic [SW-1:0]            settle_cnt;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x1[wr_ptr[AW-1:0]]  <= in_x1;
      fifo_x2[wr_ptr[AW-1:0]]  <= in_x2;
      fifo_lbl[wr_ptr[AW-1:0]] <= in_label;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        // Popping on the handshake edge keeps the MLP busy back-to-back.
        if (out_ready) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mlp_x1     <= '0;
      mlp_x2     <= '0;
      out_label  <= 1'b0;
      settle_cnt <= '0;
      out_y      <= 1'b0;
      out_match  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (pop) begin
        mlp_x1     <= fifo_x1[rd_ptr[AW-1:0]];
        mlp_x2     <= fifo_x2[rd_ptr[AW-1:0]];
        out_label  <= fifo_lbl[rd_ptr[AW-1:0]];
        settle_cnt <= '0;
      end else if (state_q == SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (capture) begin
        out_y     <= mlp_y;
        out_match <= (mlp_y == out_label);
        out_valid <= 1'b1;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear takes priority over a coincident handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count  <= '0;
      correct_count <= '0;
    end else if (clear_counts) begin
      sample_count  <= '0;
      correct_count <= '0;
    end else if (hs) begin
      sample_count <= sat_inc(sample_count);
      if (out_match) correct_count <= sat_inc(correct_count);
    end
  end

endmodule

// File: tb/tb_mlp_sample_streamer.sv
// Directed bench for mlp_sample_streamer with an MLP stub (sign of x1+x2) and a result scoreboard.
module tb_mlp_sample_streamer;

  localparam int DW = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_label, mlp_y;
  logic [DW-1:0] in_x1, in_x2, mlp_x1, mlp_x2;
  logic          out_valid, out_ready, out_y, out_label, out_match, clear_counts;
  logic [CW-1:0] sample_count, correct_count;

  mlp_sample_streamer #(.DATA_W(DW), .FIFO_DEPTH(4), .SETTLE_CYCLES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_label(in_label),
    .mlp_x1(mlp_x1), .mlp_x2(mlp_x2), .mlp_y(mlp_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_label(out_label), .out_match(out_match), .clear_counts(clear_counts),
    .sample_count(sample_count), .correct_count(correct_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] x1;
    logic [DW-1:0] x2;
    logic          lbl;
    logic          y;
  } item_t;

  item_t         sb[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            last_hs = -1;
  bit            gap_en = 0;
  bit            prev_stall = 0;
  logic          prev_y, prev_lbl, prev_match;
  logic [CW-1:0] m_sc = '0, m_cc = '0;

  function automatic logic mlp_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] s;
    s = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
    return (s >= 0);
  endfunction

  assign mlp_y = mlp_f(mlp_x1, mlp_x2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard, counter model and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_sc = '0;
      m_cc = '0;
      prev_stall = 0;
    end else begin
      chk("sample_count", 32'(sample_count), 32'(m_sc));
      chk("correct_count", 32'(correct_count), 32'(m_cc));
      if (prev_stall && out_valid) begin
        chk("hold_y", 32'(out_y), 32'(prev_y));
        chk("hold_label", 32'(out_label), 32'(prev_lbl));
        chk("hold_match", 32'(out_match), 32'(prev_match));
      end
      if (in_valid && in_ready)
        sb.push_back('{x1: in_x1, x2: in_x2, lbl: in_label, y: mlp_f(in_x1, in_x2)});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          item_t e;
          e = sb.pop_front();
          chk("out_y", 32'(out_y), 32'(e.y));
          chk("out_label", 32'(out_label), 32'(e.lbl));
          chk("out_match", 32'(out_match), 32'(e.y == e.lbl));
          chk("mlp_x1", 32'(mlp_x1), 32'(e.x1));
          chk("mlp_x2", 32'(mlp_x2), 32'(e.x2));
        end
        if (gap_en) begin
          if (last_hs >= 0) chk("result_gap", 32'(cyc - last_hs), 32'd2);
          last_hs = cyc;
        end
      end
      if (clear_counts) begin
        m_sc = '0;
        m_cc = '0;
      end else if (out_valid && out_ready) begin
        if (m_sc != '1) m_sc = m_sc + 1'b1;
        if (out_match && m_cc != '1) m_cc = m_cc + 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
      prev_lbl   = out_label;
      prev_match = out_match;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x1, input int x2, input logic lbl);
    int n;
    in_x1    = DW'(x1);
    in_x2    = DW'(x2);
    in_label = lbl;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) begin
        $display("FAIL push_timeout observed=in_ready_low expected=accept");
        $fatal(1, "push timeout");
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
  endtask

  initial begin
    int vals[5];
    int n;
    logic [DW-1:0] a, b;
    rst = 1'b1; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_label = 1'b0;
    out_ready = 1'b0; clear_counts = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mlp_x1", 32'(mlp_x1), 32'd0);
    chk("rst_out_label", 32'(out_label), 32'd0);
    chk("rst_out_match", 32'(out_match), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single sample: latency and result.
    step();
    push(2, -1, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("single_mlp_x1", 32'(mlp_x1), 32'h002);
    chk("single_mlp_x2", 32'(mlp_x2), 32'h3ff);
    chk("single_early_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_y", 32'(out_y), 32'd1);
    chk("single_match", 32'(out_match), 32'd1);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_sample_count", 32'(sample_count), 32'd1);
    chk("single_correct_count", 32'(correct_count), 32'd1);

    // Reset mid-stream with samples queued.
    step();
    push(5, 6, 1'b0); push(-7, 3, 1'b1); push(100, -200, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mlp_x2", 32'(mlp_x2), 32'd0);
    chk("midrst_count", 32'(sample_count), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst_no_spurious_valid", 32'(n), 32'd0);

    // FIFO full and pointer wrap, bit-exact extremes.
    for (int rep = 0; rep < 3; rep++) begin
      step();
      vals = '{-512, 511, 0, -1, 37 + rep};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(vals[i], vals[4 - i], logic'(i[0] ^ rep[0]));
      @(negedge clk); @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      step();
      out_ready = 1'b1;
      drain();
    end

    // Back-to-back throughput.
    step();
    pulse_clear();
    last_hs = -1;
    gap_en = 1;
    for (int i = 0; i < 8; i++) push(i * 13 - 50, 20 - i * 7, logic'(i[1]));
    drain();
    gap_en = 0;
    chk("b2b_sample_count", 32'(sample_count), 32'd8);

    // Random backpressure.
    step();
    fork
      begin
        for (int i = 0; i < 12; i++)
          push(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               logic'($urandom_range(0, 1)));
      end
      begin
        repeat (150) begin
          step();
          out_ready = logic'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Counters: 3 correct, 2 wrong, then clear on a handshake, then saturation.
    step();
    pulse_clear();
    for (int i = 0; i < 5; i++) begin
      a = DW'(i * 40 - 90);
      b = DW'(15 - i * 3);
      push(int'($signed(a)), int'($signed(b)), (i < 3) ? mlp_f(a, b) : !mlp_f(a, b));
    end
    drain();
    chk("cnt_sample_5", 32'(sample_count), 32'd5);
    chk("cnt_correct_3", 32'(correct_count), 32'd3);
    step();
    out_ready = 1'b0;
    push(9, 9, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("clear_wait_valid", 32'(out_valid), 32'd1);
    step();
    out_ready = 1'b1;
    clear_counts = 1'b1;
    step();
    out_ready = 1'b0;
    clear_counts = 1'b0;
    @(negedge clk);
    chk("clear_hs_sample", 32'(sample_count), 32'd0);
    chk("clear_hs_correct", 32'(correct_count), 32'd0);
    chk("clear_hs_done", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(i, 1, 1'b1);
    drain();
    chk("sat_sample", 32'(sample_count), 32'hf);
    chk("sat_correct", 32'(correct_count), 32'hf);
    push(-100, 1, 1'b1);
    drain();
    chk("sat_sample_hold", 32'(sample_count), 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
